// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msg_pkg
// Description : Shared widths and state encoding for the message collector
//               and framer integration.
// Revision    : 1.0
// ============================================================================
package msg_pkg;

    localparam int MSG_BITS  = 474;
    localparam int TS_BITS   = 32;
    localparam int LEN_BITS  = 9;
    localparam int MAX_BYTES = 59;
    localparam int CNT_BITS  = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        EMIT    = 3'd2,
        DISCARD = 3'd3,
        HOLD    = 3'd4
    } state_t;

    // Byte count to bit length; 59*8 = 472 still fits in LEN_BITS.
    function automatic logic [LEN_BITS-1:0] bytes_to_bits(input logic [CNT_BITS-1:0] n);
        return {n, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_counter.sv
`default_nettype none
// ============================================================================
// Module      : ts_counter
// Description : Free-running wrap-around timestamp counter, async reset to
//               TS_INIT. Shared between transmitter and receiver sides.
// Revision    : 1.0
// ============================================================================
module ts_counter
    import msg_pkg::*;
#(
    parameter logic [TS_BITS-1:0] TS_INIT = 32'd0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [TS_BITS-1:0] count
);

    logic [TS_BITS-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= TS_INIT;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/message_collector.sv
`default_nettype none
// ============================================================================
// Module      : message_collector
// Description : Collects a valid/ready byte stream into a 474-bit MSB-first
//               message with timestamp and bit length, then pulses start.
// Revision    : 1.0
// ============================================================================
module message_collector
    import msg_pkg::*;
#(
    parameter int                 HOLD_CYCLES = 4,
    parameter logic [TS_BITS-1:0] TS_INIT     = 32'd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic                start,
    output logic [TS_BITS-1:0]  timestamp,
    output logic [LEN_BITS-1:0] length,
    output logic [MSG_BITS-1:0] message,
    output logic                trunc
);

    // HOLD_CYCLES is expected to be at least 1.
    localparam int                  c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] c_cnt_one   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] c_cnt_max   = CNT_BITS'(MAX_BYTES);

    state_t              r_state;
    logic                r_in_ready;
    logic                r_start;
    logic                r_trunc;
    logic [TS_BITS-1:0]  r_ts_out;
    logic [LEN_BITS-1:0] r_len;
    logic [MSG_BITS-1:0] r_msg;
    logic [MSG_BITS-1:0] r_buf;
    logic [TS_BITS-1:0]  r_ts_work;
    logic [CNT_BITS-1:0] r_count;
    logic [c_hold_w-1:0] r_hold_cnt;

    logic [TS_BITS-1:0]  w_ts;
    logic                w_accept;
    logic                w_first;
    logic [CNT_BITS-1:0] w_idx;
    logic [CNT_BITS-1:0] w_next_count;
    logic                w_full;
    logic [MSG_BITS-1:0] w_ins;
    logic [MSG_BITS-1:0] w_next_buf;

    ts_counter #(
        .TS_INIT (TS_INIT)
    ) u_ts_counter (
        .clk   (clk),
        .reset (reset),
        .count (w_ts)
    );

    assign w_accept     = in_valid & r_in_ready;
    assign w_first      = (r_state == IDLE);
    assign w_idx        = w_first ? '0 : r_count;
    assign w_next_count = w_idx + c_cnt_one;
    assign w_full       = (w_next_count == c_cnt_max);

    // Byte k lands at [473-8k -: 8]; a new message starts from a cleared buffer.
    assign w_ins        = {in_data, {(MSG_BITS-8){1'b0}}} >> {w_idx, 3'b000};
    assign w_next_buf   = (w_first ? '0 : r_buf) | w_ins;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_start    <= 1'b0;
            r_trunc    <= 1'b0;
            r_ts_out   <= '0;
            r_len      <= '0;
            r_msg      <= '0;
            r_buf      <= '0;
            r_ts_work  <= '0;
            r_count    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_buf   <= w_next_buf;
                        r_count <= w_next_count;
                        if (w_first) begin
                            r_ts_work <= w_ts;
                        end
                        if (in_last || w_full) begin
                            // Output registers load here so they are valid with start.
                            r_state    <= EMIT;
                            r_in_ready <= 1'b0;
                            r_start    <= 1'b1;
                            r_trunc    <= ~in_last;
                            r_msg      <= w_next_buf;
                            r_len      <= bytes_to_bits(w_next_count);
                            r_ts_out   <= w_first ? w_ts : r_ts_work;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end
                EMIT: begin
                    if (r_trunc) begin
                        r_state    <= DISCARD;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state    <= HOLD;
                        r_in_ready <= 1'b0;
                        r_hold_cnt <= c_hold_load;
                    end
                end
                DISCARD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && in_last) begin
                        r_state    <= HOLD;
                        r_in_ready <= 1'b0;
                        r_hold_cnt <= c_hold_load;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign start     = r_start;
    assign trunc     = r_trunc;
    assign timestamp = r_ts_out;
    assign length    = r_len;
    assign message   = r_msg;

endmodule
`default_nettype wire
